sdram_init_ref_ctrl: RTL and testbench
======================================

# sdram_init_ref_ctrl

Power-up initialization and refresh controller for the SDRAM controller. After reset it drives the JEDEC init sequence: power-up wait, PRECHARGE ALL, N AUTO REFRESH, MODE REGISTER SET. It then schedules periodic auto-refresh and arbitrates the command bus between refresh and a single host access engine. Its command/address outputs feed the command bus mux ahead of the SDRAM pins.

## Interface
- INIT_WAIT, 10000: power-up wait in cycles (100 µs @ 100 MHz)
- T_RP, 3: precharge-to-next-command cycles (≥1)
- T_RFC, 7: refresh-to-next-command cycles (≥1)
- T_MRD, 2: MRS-to-next-command cycles (≥1)
- INIT_REFRESHES, 8: auto-refresh count during init (≥1)
- REFRESH_PERIOD, 780: cycles between refresh requests (7.8 µs)
- MODE_VALUE, 12'h033: mode register word (BL8, sequential, CL3)
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- cmd  out  4  {cs_n, ras_n, cas_n, we_n}
- addr  out  12  SDRAM address; A10=1 on PRECHARGE ALL, MODE_VALUE on MRS, else 0
- init_done  out  1  high from first IDLE entry until reset
- host_req  in  1  level; host requests the command bus
- host_gnt  out  1  high while host owns the bus
- host_done  in  1  one-cycle pulse; host releases the bus
- ref_miss  out  1  one-cycle pulse; refresh interval expired with a refresh still pending

## Operation
- Encodings: INHIBIT 4'b1111, NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001, MRS 4'b0000.
- States: PWR_WAIT, PRE, WAIT_RP, REF, WAIT_RFC, MRS, WAIT_MRD, IDLE, HOST, AREF, AREF_WAIT.
- PWR_WAIT: cmd=INHIBIT for INIT_WAIT cycles, then PRE.
- PRE: one cycle PRECHARGE with addr[10]=1. WAIT_RP: NOP for T_RP-1 cycles. Then REF.
- REF: one cycle AUTO_REFRESH. WAIT_RFC: NOP for T_RFC-1 cycles. Return to REF until INIT_REFRESHES commands are issued, then go to MRS.
- MRS: one cycle MRS with addr=MODE_VALUE. WAIT_MRD: NOP for T_MRD-1 cycles. Then IDLE and set init_done.
- IDLE: cmd=NOP.
  - Pending refresh goes to AREF. Refresh has priority over a simultaneous host_req.
  - Otherwise host_req goes to HOST.
- HOST: host_gnt=1, cmd=NOP (the external mux selects the host). host_done returns to IDLE. host_req is ignored while in HOST.
- AREF: one cycle AUTO_REFRESH, clears pending. AREF_WAIT: NOP for T_RFC-1 cycles. Then IDLE.
- Refresh timer: free-running from IDLE entry at init end. Reloads every REFRESH_PERIOD cycles. Each expiry sets pending.
  - If pending is already set at expiry, pulse ref_miss. Pending stays a single flag; no count.
  - An expiry in the same cycle as the AREF clear leaves pending set.
- host_done outside HOST is ignored.
- Reset at any time: immediate return to PWR_WAIT and the full init sequence reruns.

## Timing
- Reset values: cmd=INHIBIT, addr=0, init_done=0, host_gnt=0, ref_miss=0. All outputs are registered.
- A command issued at cycle c puts the next command at c+T_x. First PRECHARGE appears at cycle INIT_WAIT after reset release.
- Full init length: INIT_WAIT + T_RP + INIT_REFRESHES·T_RFC + T_MRD cycles to init_done=1.
- Grant latency: host_req sampled in IDLE gives host_gnt=1 the next cycle.
- Release: host_done at cycle c gives host_gnt=0 at c+1 (IDLE). A new grant is possible at c+2 at the earliest.
- Refresh latency from expiry:
  - 1 cycle to AUTO_REFRESH if IDLE.
  - If HOST, the AUTO_REFRESH comes 2 cycles after host_done.
  - If busy in AREF_WAIT, it follows that window.

## Structure
- Package sdram_pkg holds:
  - the command enum (shared by all command sequence generators),
  - the controller state enum,
  - the A10 bit-index constant.
- Sub-module sdram_wait_timer: a loadable down-counter with zero flag, reused for PWR_WAIT and the tRP/tRFC/tMRD waits. The refresh interval counter and the init-refresh counter stay inline.

## Test plan
- Init with INIT_WAIT=10, T_RP=2, T_RFC=3, T_MRD=2, INIT_REFRESHES=2 → PRECHARGE at cycle 10 (addr[10]=1), AUTO_REFRESH at 12 and 15, MRS at 18 with addr=12'h033, init_done=1 at 20.
- Idle with REFRESH_PERIOD=20 → AUTO_REFRESH every 20 cycles, NOP otherwise, ref_miss never pulses.
- host_req rises in the same cycle the refresh expires → AUTO_REFRESH first, host_gnt=1 one cycle after AREF_WAIT ends.
- Refresh expires during HOST; host_done 5 cycles later → host_gnt drops next cycle, AUTO_REFRESH follows one cycle after.
- Host holds the bus for 2·REFRESH_PERIOD cycles → exactly one ref_miss pulse, then a single AUTO_REFRESH after release.
- n_rst pulsed low during WAIT_RFC of init → cmd=INHIBIT and init_done=0 immediately, full sequence restarts with the same cycle counts.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM init/refresh controller: command encodings,
// controller states and the address bit that selects PRECHARGE ALL.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_INHIBIT      = 4'b1111,
    CMD_NOP          = 4'b0111,
    CMD_PRECHARGE    = 4'b0010,
    CMD_AUTO_REFRESH = 4'b0001,
    CMD_MRS          = 4'b0000
  } cmd_e;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_PRE,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC,
    ST_MRS,
    ST_WAIT_MRD,
    ST_IDLE,
    ST_HOST,
    ST_AREF,
    ST_AREF_WAIT
  } state_e;

  localparam int A10_BIT = 10;

  // The command cycle plus the wait state together span t cycles, so the
  // wait state's down-counter starts at t-2 (no wait state at all when t==1).
  function automatic int wait_load(int t);
    return (t > 2) ? t - 2 : 0;
  endfunction

endpackage

// File: rtl/sdram_init_ref_ctrl_if.sv
// Command bus and host arbitration signals between the init/refresh
// controller (master) and the command mux / host engine (slave).
interface sdram_init_ref_ctrl_if;
  import sdram_pkg::*;

  cmd_e        cmd;
  logic [11:0] addr;
  logic        init_done;
  logic        host_req;
  logic        host_gnt;
  logic        host_done;
  logic        ref_miss;

  modport master (
    output cmd, addr, init_done, host_gnt, ref_miss,
    input  host_req, host_done
  );

  modport slave (
    input  cmd, addr, init_done, host_gnt, ref_miss,
    output host_req, host_done
  );
endinterface

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter that parks at zero; zero flags the end of a wait.
module sdram_wait_timer #(
  parameter int             W           = 16,
  parameter logic [W-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= RESET_VALUE;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);
endmodule

// File: rtl/sdram_init_ref_ctrl.sv
// SDRAM power-up init sequencer, periodic auto-refresh scheduler and
// command-bus arbiter between refresh and a single host engine.
module sdram_init_ref_ctrl
  import sdram_pkg::*;
#(
  parameter int          INIT_WAIT      = 10000,
  parameter int          T_RP           = 3,
  parameter int          T_RFC          = 7,
  parameter int          T_MRD          = 2,
  parameter int          INIT_REFRESHES = 8,
  parameter int          REFRESH_PERIOD = 780,
  parameter logic [11:0] MODE_VALUE     = 12'h033
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sdram_init_ref_ctrl_if.master bus
);
  localparam int TW = $clog2(INIT_WAIT + T_RP + T_RFC + T_MRD + 1);
  localparam int RW = $clog2(REFRESH_PERIOD + 1);
  localparam int CW = $clog2(INIT_REFRESHES + 1);
  localparam logic [TW-1:0] LOAD_RP  = TW'(wait_load(T_RP));
  localparam logic [TW-1:0] LOAD_RFC = TW'(wait_load(T_RFC));
  localparam logic [TW-1:0] LOAD_MRD = TW'(wait_load(T_MRD));

  state_e        state_reg, state_next;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_zero;
  logic [CW-1:0] ref_cnt_reg, ref_cnt_next;
  logic          ref_last;
  logic [RW-1:0] rtmr_reg;
  logic          expiry, pending_reg, ref_due;
  cmd_e          cmd_reg, cmd_next;
  logic [11:0]   addr_reg, addr_next;
  logic          init_done_reg, host_gnt_reg, ref_miss_reg;

  sdram_wait_timer #(
    .W           (TW),
    .RESET_VALUE (TW'(INIT_WAIT - 1))
  ) u_wait_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  // In REF the counter has not yet counted the refresh being issued.
  assign ref_last = (state_reg == ST_REF) ? (ref_cnt_reg == CW'(INIT_REFRESHES - 1))
                                          : (ref_cnt_reg == CW'(INIT_REFRESHES));
  assign expiry   = init_done_reg && (rtmr_reg == '0);
  assign ref_due  = pending_reg || expiry;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= ST_PWR_WAIT;
      ref_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ref_cnt_reg <= ref_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    ref_cnt_next = ref_cnt_reg;
    case (state_reg)
      ST_PWR_WAIT: if (tmr_zero) state_next = ST_PRE;
      ST_PRE: begin
        tmr_load   = 1'b1;
        tmr_value  = LOAD_RP;
        state_next = (T_RP > 1) ? ST_WAIT_RP : ST_REF;
      end
      ST_WAIT_RP: if (tmr_zero) state_next = ST_REF;
      ST_REF: begin
        tmr_load     = 1'b1;
        tmr_value    = LOAD_RFC;
        ref_cnt_next = ref_cnt_reg + 1'b1;
        if (T_RFC > 1) state_next = ST_WAIT_RFC;
        else           state_next = ref_last ? ST_MRS : ST_REF;
      end
      ST_WAIT_RFC: if (tmr_zero) state_next = ref_last ? ST_MRS : ST_REF;
      ST_MRS: begin
        tmr_load   = 1'b1;
        tmr_value  = LOAD_MRD;
        state_next = (T_MRD > 1) ? ST_WAIT_MRD : ST_IDLE;
      end
      ST_WAIT_MRD: if (tmr_zero) state_next = ST_IDLE;
      ST_IDLE: begin
        if (ref_due)           state_next = ST_AREF;
        else if (bus.host_req) state_next = ST_HOST;
      end
      ST_HOST: if (bus.host_done) state_next = ST_IDLE;
      ST_AREF: begin
        tmr_load   = 1'b1;
        tmr_value  = LOAD_RFC;
        state_next = (T_RFC > 1) ? ST_AREF_WAIT : ST_IDLE;
      end
      ST_AREF_WAIT: if (tmr_zero) state_next = ST_IDLE;
      default: state_next = ST_PWR_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they belong to.
  always_comb begin
    cmd_next  = CMD_NOP;
    addr_next = '0;
    case (state_next)
      ST_PWR_WAIT: cmd_next = CMD_INHIBIT;
      ST_PRE: begin
        cmd_next           = CMD_PRECHARGE;
        addr_next[A10_BIT] = 1'b1;
      end
      ST_REF, ST_AREF: cmd_next = CMD_AUTO_REFRESH;
      ST_MRS: begin
        cmd_next  = CMD_MRS;
        addr_next = MODE_VALUE;
      end
      default: cmd_next = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_reg       <= CMD_INHIBIT;
      addr_reg      <= '0;
      init_done_reg <= 1'b0;
      host_gnt_reg  <= 1'b0;
    end else begin
      cmd_reg       <= cmd_next;
      addr_reg      <= addr_next;
      init_done_reg <= init_done_reg || (state_next == ST_IDLE);
      host_gnt_reg  <= (state_next == ST_HOST);
    end
  end

  // Refresh interval timer holds its preload until init completes, then
  // free-runs; an expiry coinciding with the AREF clear wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rtmr_reg     <= RW'(REFRESH_PERIOD - 1);
      pending_reg  <= 1'b0;
      ref_miss_reg <= 1'b0;
    end else begin
      if (!init_done_reg || expiry) rtmr_reg <= RW'(REFRESH_PERIOD - 1);
      else                          rtmr_reg <= rtmr_reg - 1'b1;
      if (expiry)                       pending_reg <= 1'b1;
      else if (state_reg == ST_AREF)    pending_reg <= 1'b0;
      ref_miss_reg <= expiry && pending_reg;
    end
  end

  assign bus.cmd       = cmd_reg;
  assign bus.addr      = addr_reg;
  assign bus.init_done = init_done_reg;
  assign bus.host_gnt  = host_gnt_reg;
  assign bus.ref_miss  = ref_miss_reg;
endmodule

// File: tb/tb_sdram_init_ref_ctrl.sv
// Scoreboard bench: expected bus events (commands, grant edges, init_done,
// ref_miss) are queued with their cycle; a monitor pops and compares.
module tb_sdram_init_ref_ctrl;
  import sdram_pkg::*;

  localparam int INIT_WAIT = 10;
  localparam int K_CMD = 0, K_GNT = 1, K_DONE = 2, K_MISS = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   done;
  logic gnt_prev, done_prev;
  ev_t  exp_q[$];

  sdram_init_ref_ctrl_if bus();

  sdram_init_ref_ctrl #(
    .INIT_WAIT      (INIT_WAIT),
    .T_RP           (2),
    .T_RFC          (3),
    .T_MRD          (2),
    .INIT_REFRESHES (2),
    .REFRESH_PERIOD (20),
    .MODE_VALUE     (12'h033)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] cv(cmd_e c, logic [11:0] a);
    return {c, a};
  endfunction

  task automatic expect_ev(int c, int k, logic [15:0] v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("check %s: %h ok (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic take_event(int kind, logic [15:0] val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d val=%h cycle=%0d, required no event",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind=%0d val=%h cycle=%0d, required kind=%0d val=%h cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end else begin
        $display("cycle %0d: event kind=%0d val=%h ok", cyc, kind, val);
      end
    end
  endtask

  task automatic monitor_step();
    ev_t e;
    if (n_rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_event: got nothing by cycle %0d, required kind=%0d val=%h cycle=%0d",
                 cyc, e.kind, e.val, e.cyc);
      end
      if (bus.cmd != CMD_NOP && !(bus.cmd == CMD_INHIBIT && cyc < INIT_WAIT))
        take_event(K_CMD, {bus.cmd, bus.addr});
      if (bus.host_gnt != gnt_prev)   take_event(K_GNT, 16'(bus.host_gnt));
      if (bus.init_done != done_prev) take_event(K_DONE, 16'(bus.init_done));
      if (bus.ref_miss)               take_event(K_MISS, 16'd1);
    end
    gnt_prev  = bus.host_gnt;
    done_prev = bus.init_done;
  endtask

  task automatic wait_cyc(int k);
    int guard;
    guard = 0;
    while (cyc != k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cyc: got cycle %0d, required %0d", cyc, k);
    end
  endtask

  task automatic pulse_done(bit drop_req);
    bus.host_done = 1'b1;
    if (drop_req) bus.host_req = 1'b0;
    @(negedge clk);
    bus.host_done = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; done = 1'b0;
    gnt_prev = 1'b0; done_prev = 1'b0;
    n_rst = 1'b0;
    bus.host_req = 1'b0;
    bus.host_done = 1'b0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          monitor_step();
        end
      end
      begin
        repeat (3) @(negedge clk);
        chk("reset_cmd", 16'(bus.cmd), 16'(CMD_INHIBIT));
        chk("reset_addr", 16'(bus.addr), 16'h0000);
        chk("reset_init_done", 16'(bus.init_done), 16'h0);
        chk("reset_host_gnt", 16'(bus.host_gnt), 16'h0);
        chk("reset_ref_miss", 16'(bus.ref_miss), 16'h0);

        // Partial init, then reset in WAIT_RFC.
        expect_ev(10, K_CMD, cv(CMD_PRECHARGE, 12'h400));
        expect_ev(12, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        n_rst = 1'b1;
        wait_cyc(13);
        n_rst = 1'b0;
        #1;
        chk("midreset_cmd", 16'(bus.cmd), 16'(CMD_INHIBIT));
        chk("midreset_init_done", 16'(bus.init_done), 16'h0);
        chk("midreset_queue_left", 16'(exp_q.size()), 16'd0);
        @(negedge clk);
        @(negedge clk);

        // Full init after the restart, then idle refreshes.
        expect_ev(10, K_CMD, cv(CMD_PRECHARGE, 12'h400));
        expect_ev(12, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        expect_ev(15, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        expect_ev(18, K_CMD, cv(CMD_MRS, 12'h033));
        expect_ev(20, K_DONE, 16'd1);
        expect_ev(40, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        expect_ev(60, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        n_rst = 1'b1;
        wait_cyc(50);
        pulse_done(1'b0);

        // host_req together with refresh expiry: refresh first.
        expect_ev(80, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        expect_ev(84, K_GNT, 16'd1);
        wait_cyc(79);
        bus.host_req = 1'b1;

        // Expiry at 99 during HOST, release at 104.
        expect_ev(105, K_GNT, 16'd0);
        expect_ev(106, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        wait_cyc(104);
        pulse_done(1'b1);

        // Bus held for two refresh periods: one ref_miss, one catch-up refresh.
        expect_ev(111, K_GNT, 16'd1);
        expect_ev(140, K_MISS, 16'd1);
        expect_ev(152, K_GNT, 16'd0);
        expect_ev(153, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        expect_ev(160, K_CMD, cv(CMD_AUTO_REFRESH, 12'h000));
        wait_cyc(110);
        bus.host_req = 1'b1;
        wait_cyc(151);
        pulse_done(1'b1);

        // Back-to-back grant: earliest re-grant two cycles after host_done.
        expect_ev(165, K_GNT, 16'd1);
        expect_ev(168, K_GNT, 16'd0);
        expect_ev(169, K_GNT, 16'd1);
        expect_ev(172, K_GNT, 16'd0);
        wait_cyc(164);
        bus.host_req = 1'b1;
        wait_cyc(167);
        pulse_done(1'b0);
        wait_cyc(171);
        pulse_done(1'b1);

        wait_cyc(176);
        chk("final_queue_left", 16'(exp_q.size()), 16'd0);
        chk("final_init_done", 16'(bus.init_done), 16'h1);
        chk("final_cmd_nop", 16'(bus.cmd), 16'(CMD_NOP));
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
